// File: rtl/pci_initiator.sv
// PCI bus master: one address phase, up to MAX_BURST data phases, turnaround on reads,
// master abort when no target claims within DEVSEL_TIMEOUT cycles.
module pci_initiator #(
  parameter int MAX_BURST      = 4,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic        clk,
  input  logic        r,
  input  logic        req,
  input  logic [3:0]  cmd,
  input  logic [31:0] addr,
  input  logic [2:0]  len,
  input  logic [31:0] wd,
  input  logic [3:0]  wbe,
  input  logic        wd_empty,
  output logic        wd_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        frame,
  output logic        irdy,
  output logic [3:0]  cbe,
  output logic        rw,
  inout  wire  [31:0] AD,
  input  logic        DEVSEL,
  input  logic        TRDY,
  output logic        busy,
  output logic        done,
  output logic        abort
);
  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ADDR, TURN, DATA, ABRT, FIN} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cmd_reg;
  logic [31:0]   addr_reg, hold_reg, rd_data_reg;
  logic [2:0]    rem_reg, len_clamped;
  logic [TW-1:0] tcnt_reg, tcnt_inc;
  logic          claimed_reg, abort_reg, rd_valid_reg;
  logic          is_wr, xfer, timeout_hit, drive_cbe, irdy_dat;
  logic [3:0]    cbe_out;
  logic [31:0]   ad_out;

  assign is_wr       = cmd_reg[0];
  assign tcnt_inc    = tcnt_reg + 1'b1;
  assign timeout_hit = !claimed_reg && DEVSEL && (tcnt_inc == TW'(DEVSEL_TIMEOUT));

  always_comb begin
    if (len == 3'd0)                  len_clamped = 3'd1;
    else if (len > 3'(MAX_BURST))     len_clamped = 3'(MAX_BURST);
    else                              len_clamped = len;
  end

  always_comb begin
    state_next = state_reg;
    frame      = 1'b1;
    irdy       = 1'b1;
    irdy_dat   = 1'b1;
    rw         = 1'b0;
    cbe_out    = 4'b1111;
    drive_cbe  = 1'b0;
    ad_out     = hold_reg;
    xfer       = 1'b0;
    wd_pop     = 1'b0;
    done       = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      IDLE: if (req) state_next = ADDR;
      ADDR: begin
        frame      = 1'b0;
        rw         = 1'b1;
        ad_out     = addr_reg;
        cbe_out    = cmd_reg;
        drive_cbe  = 1'b1;
        state_next = is_wr ? DATA : TURN;
      end
      TURN: begin
        frame      = 1'b0;
        irdy       = 1'b0;
        drive_cbe  = 1'b1;
        state_next = timeout_hit ? ABRT : DATA;
      end
      DATA: begin
        drive_cbe = 1'b1;
        cbe_out   = is_wr ? wbe : 4'b1111;
        rw        = is_wr;
        // An empty write buffer inserts an initiator wait; AD keeps the last word driven.
        irdy_dat  = is_wr && wd_empty;
        irdy      = irdy_dat;
        ad_out    = (is_wr && !wd_empty) ? wd : hold_reg;
        frame     = (rem_reg == 3'd1) && !irdy_dat;
        xfer      = !irdy_dat && !TRDY;
        wd_pop    = xfer && is_wr;
        if (xfer && rem_reg == 3'd1) state_next = FIN;
        else if (timeout_hit)        state_next = ABRT;
      end
      ABRT: begin
        irdy       = 1'b0;
        rw         = is_wr;
        drive_cbe  = 1'b1;
        state_next = FIN;
      end
      FIN: begin
        done       = !abort_reg;
        abort      = abort_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_reg    <= IDLE;
      cmd_reg      <= '0;
      addr_reg     <= '0;
      hold_reg     <= '0;
      rd_data_reg  <= '0;
      rem_reg      <= '0;
      tcnt_reg     <= '0;
      claimed_reg  <= 1'b0;
      abort_reg    <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= 1'b0;
      if (state_reg == IDLE && req) begin
        cmd_reg     <= cmd;
        addr_reg    <= addr;
        hold_reg    <= addr;
        rem_reg     <= len_clamped;
        tcnt_reg    <= '0;
        claimed_reg <= 1'b0;
        abort_reg   <= 1'b0;
      end
      // The timeout only runs until the first DEVSEL claim; later deassertion is ignored.
      if ((state_reg == TURN || state_reg == DATA) && !claimed_reg) begin
        if (!DEVSEL) claimed_reg <= 1'b1;
        else         tcnt_reg    <= tcnt_inc;
      end
      if (state_reg == DATA) begin
        if (is_wr && !wd_empty) hold_reg <= wd;
        if (xfer) begin
          rem_reg <= rem_reg - 3'd1;
          if (!is_wr) begin
            rd_data_reg  <= AD;
            rd_valid_reg <= 1'b1;
          end
        end
      end
      if (state_next == ABRT) abort_reg <= 1'b1;
    end
  end

  assign cbe      = drive_cbe ? cbe_out : 4'bzzzz;
  assign AD       = rw ? ad_out : 32'hzzzz_zzzz;
  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = (state_reg != IDLE);
endmodule

// File: tb/tb_pci_initiator.sv
// Bench for pci_initiator: the bench acts as target and local buffer, predicting each
// cycle's bus handshake and the per-transaction word counts from the protocol rules.
module tb_pci_initiator;
  localparam int MAXB = 4;
  localparam int TMO  = 5;

  logic        clk = 1'b0, r = 1'b1, req = 1'b0;
  logic [3:0]  cmd = '0, wbe = '0, cbe;
  logic [31:0] addr = '0, wd = '0, rd_data, tb_ad = '0;
  logic [2:0]  len = '0;
  logic        wd_empty = 1'b1, wd_pop, rd_valid, frame, irdy, rw;
  logic        DEVSEL = 1'b1, TRDY = 1'b1, busy, done, abort, tb_drive = 1'b0;
  wire  [31:0] AD;
  int          n_cmp = 0, n_err = 0;

  assign AD = tb_drive ? tb_ad : 32'hzzzz_zzzz;
  always #5 clk = ~clk;

  pci_initiator #(.MAX_BURST(MAXB), .DEVSEL_TIMEOUT(TMO)) dut (
    .clk(clk), .r(r), .req(req), .cmd(cmd), .addr(addr), .len(len), .wd(wd), .wbe(wbe),
    .wd_empty(wd_empty), .wd_pop(wd_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .frame(frame), .irdy(irdy), .cbe(cbe), .rw(rw), .AD(AD), .DEVSEL(DEVSEL), .TRDY(TRDY),
    .busy(busy), .done(done), .abort(abort)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [2:0]  l;
    int          wp;
    bit          nodev;
    int          exp_n;
  } vec_t;

  // One full transaction; pops/rvs are counted from the DUT outputs.
  task automatic do_txn(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l,
                        input int wp, input bit nodev, output int pops, output int rvs);
    int n, xf, dcnt, guard;
    bit wr, emp, trd, ex_xfer, prev_rd;
    logic [31:0] prev_w, last_ad;
    logic [3:0] be;
    logic [31:0] words[MAXB];
    n  = (l == 0) ? 1 : ((int'(l) > MAXB) ? MAXB : int'(l));
    wr = c[0];
    pops = 0; rvs = 0; xf = 0; dcnt = 0; guard = 0; prev_rd = 0; prev_w = '0; last_ad = a;
    be = 4'($urandom);
    for (int i = 0; i < MAXB; i++) words[i] = $urandom;
    @(negedge clk);
    req = 1; cmd = c; addr = a; len = l; wbe = be; DEVSEL = 1; TRDY = 1; wd_empty = 1; tb_drive = 0;
    #1 chk("idle_busy", 32'(busy), 0);
    @(negedge clk);
    req = 0;
    #1;
    chk("addr_frame", 32'(frame), 0); chk("addr_irdy", 32'(irdy), 1);
    chk("addr_rw", 32'(rw), 1);       chk("addr_ad", AD, a);
    chk("addr_cbe", 32'(cbe), 32'(c)); chk("addr_busy", 32'(busy), 1);
    if (!wr) begin
      @(negedge clk);
      DEVSEL = nodev;
      #1;
      chk("turn_rw", 32'(rw), 0);     chk("turn_irdy", 32'(irdy), 0);
      chk("turn_frame", 32'(frame), 0); chk("turn_cbe", 32'(cbe), 32'hF);
      if (nodev) dcnt++;
    end
    while (xf < n && !(nodev && dcnt == TMO) && guard < 100) begin
      @(negedge clk);
      emp = wr && !nodev && ($urandom_range(99) < wp);
      trd = nodev || ($urandom_range(99) < wp);
      wd = words[xf]; wd_empty = emp; TRDY = trd; DEVSEL = nodev;
      tb_ad = words[xf]; tb_drive = !wr;
      #1;
      ex_xfer = !emp && !trd;
      chk("data_irdy", 32'(irdy), 32'(emp));
      chk("data_frame", 32'(frame), 32'((n - xf == 1) && !emp));
      chk("data_rw", 32'(rw), 32'(wr));
      chk("data_cbe", 32'(cbe), wr ? 32'(be) : 32'hF);
      chk("data_pop", 32'(wd_pop), 32'(wr && ex_xfer));
      chk("data_rdv", 32'(rd_valid), 32'(prev_rd));
      if (prev_rd) chk("data_rdd", rd_data, prev_w);
      if (wr) begin
        if (!emp) last_ad = words[xf];
        chk("data_ad", AD, last_ad);
      end
      pops += int'(wd_pop); rvs += int'(rd_valid);
      prev_rd = !wr && ex_xfer; prev_w = words[xf];
      if (ex_xfer) xf++;
      if (nodev) dcnt++;
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++; n_err++;
      $display("FAIL txn_timeout: got %0d phases expected %0d", xf, n);
    end
    if (nodev) begin
      @(negedge clk);
      tb_drive = 0;
      #1;
      chk("abrt_frame", 32'(frame), 1); chk("abrt_irdy", 32'(irdy), 0);
      chk("abrt_pop", 32'(wd_pop), 0);  chk("abrt_busy", 32'(busy), 1);
    end
    @(negedge clk);
    tb_drive = 1; tb_ad = '0; DEVSEL = 1; TRDY = 1; wd_empty = 1;
    #1;
    chk("fin_frame", 32'(frame), 1); chk("fin_irdy", 32'(irdy), 1);
    chk("fin_rw", 32'(rw), 0);       chk("fin_ad_free", AD, 0);
    chk("fin_busy", 32'(busy), 1);   chk("fin_done", 32'(done), 32'(!nodev));
    chk("fin_abort", 32'(abort), 32'(nodev));
    chk("fin_rdv", 32'(rd_valid), 32'(prev_rd));
    if (prev_rd) chk("fin_rdd", rd_data, prev_w);
    rvs += int'(rd_valid);
    @(negedge clk);
    tb_drive = 0;
    #1;
    chk("post_busy", 32'(busy), 0); chk("post_done", 32'(done), 0);
    chk("post_abort", 32'(abort), 0); chk("post_rdv", 32'(rd_valid), 0);
  endtask

  vec_t tbl[8];

  initial begin
    int pops, rvs, en;
    vec_t v;
    tbl[0] = '{4'b0111, 32'h0,        3'd3, 0,  1'b0, 3};
    tbl[1] = '{4'b0110, 32'h100,      3'd3, 0,  1'b0, 3};
    tbl[2] = '{4'b0110, 32'h200,      3'd2, 50, 1'b0, 2};
    tbl[3] = '{4'b0111, 32'h300,      3'd2, 50, 1'b0, 2};
    tbl[4] = '{4'b0111, 32'h400,      3'd0, 0,  1'b0, 1};
    tbl[5] = '{4'b0110, 32'h500,      3'd7, 30, 1'b0, 4};
    tbl[6] = '{4'b0111, 32'hDEAD_0000, 3'd2, 0,  1'b1, 0};
    tbl[7] = '{4'b0110, 32'hBEEF_0000, 3'd4, 0,  1'b1, 0};

    tb_drive = 1; tb_ad = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_frame", 32'(frame), 1); chk("rst_irdy", 32'(irdy), 1);
    chk("rst_rw", 32'(rw), 0);       chk("rst_ad_free", AD, 0);
    chk("rst_busy", 32'(busy), 0);   chk("rst_done", 32'(done), 0);
    chk("rst_abort", 32'(abort), 0); chk("rst_rdv", 32'(rd_valid), 0);
    chk("rst_pop", 32'(wd_pop), 0);
    r = 0; tb_drive = 0;

    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      do_txn(v.c, v.a, v.l, v.wp, v.nodev, pops, rvs);
      chk("tbl_pops", 32'(pops), v.c[0] ? 32'(v.exp_n) : 0);
      chk("tbl_rvs",  32'(rvs),  v.c[0] ? 0 : 32'(v.exp_n));
      $display("txn tbl%0d cmd=%b len=%0d pops=%0d rd_valid=%0d", i, v.c, v.l, pops, rvs);
    end

    for (int i = 0; i < 16; i++) begin
      v.c = ($urandom_range(1) == 1) ? 4'b0111 : 4'b0110;
      v.a = $urandom;
      v.l = 3'($urandom_range(7));
      v.wp = $urandom_range(60);
      v.nodev = ($urandom_range(7) == 0);
      en = v.nodev ? 0 : ((v.l == 0) ? 1 : ((int'(v.l) > MAXB) ? MAXB : int'(v.l)));
      do_txn(v.c, v.a, v.l, v.wp, v.nodev, pops, rvs);
      chk("rnd_pops", 32'(pops), v.c[0] ? 32'(en) : 0);
      chk("rnd_rvs",  32'(rvs),  v.c[0] ? 0 : 32'(en));
      $display("txn rnd%0d cmd=%b len=%0d nodev=%0d pops=%0d rd_valid=%0d", i, v.c, v.l, v.nodev, pops, rvs);
    end

    // Reset in the middle of a 4-phase write burst.
    @(negedge clk);
    req = 1; cmd = 4'b0111; addr = 32'h1234_0000; len = 3'd4; DEVSEL = 0; TRDY = 0; wd_empty = 0; wd = 32'hCAFE_0001;
    @(negedge clk);
    req = 0;
    repeat (2) @(negedge clk);
    #1 chk("mid_busy_before", 32'(busy), 1);
    r = 1; tb_drive = 1; tb_ad = '0;
    #1;
    chk("mid_frame", 32'(frame), 1); chk("mid_irdy", 32'(irdy), 1);
    chk("mid_rw", 32'(rw), 0);       chk("mid_ad_free", AD, 0);
    chk("mid_busy", 32'(busy), 0);   chk("mid_done", 32'(done), 0);
    chk("mid_pop", 32'(wd_pop), 0);
    $display("txn reset-mid-burst frame=%0d irdy=%0d busy=%0d", frame, irdy, busy);
    @(negedge clk);
    r = 0; tb_drive = 0; DEVSEL = 1; TRDY = 1;
    @(negedge clk);
    #1 chk("after_rst_busy", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
